// File: rtl/fir_pkg.sv
// Shared sizes, state encoding and helpers for the 10-tap FIR sequencing controller.
package fir_pkg;

  localparam int NUM_TAP  = 10;
  localparam int SAMPLE_W = 3;
  localparam int COEFF_W  = 16;
  localparam int ADDR_W   = 4;
  localparam int LAST_TAP = NUM_TAP - 1;
  localparam int DELAY_W  = NUM_TAP * SAMPLE_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_TAP);

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    READ,
    DRAIN,
    CAPTURE
  } state_t;

  // Host writes above the last tap have no backing SRAM word.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr <= LAST_ADDR;
  endfunction

endpackage

// File: rtl/fir_delay_chain.sv
// Input sample delay line: newest sample enters at [SAMPLE_W-1:0], oldest leaves at the top.
module fir_delay_chain
  import fir_pkg::*;
(
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iShift,
  input  logic [SAMPLE_W-1:0] iSample,
  output logic [DELAY_W-1:0]  oDelay
);

  logic [DELAY_W-1:0] r_delay;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_delay <= '0;
    end else if (iShift) begin
      r_delay <= {r_delay[DELAY_W-SAMPLE_W-1:0], iSample};
    end
  end

  assign oDelay = r_delay;

endmodule

// File: rtl/fir_mac_sched.sv
// Sequencing controller for the 10-tap FIR: delay chain, coefficient SRAM port and MAC enable.
// Optional sticky dropped-sample flag enabled by defining FIR_SAMPLE_OVF_EN.
module fir_mac_sched
  import fir_pkg::*;
(
  input  logic                iClk12M,
  input  logic                iRst,
  input  logic                iEnSample,
  input  logic [SAMPLE_W-1:0] iFirIn,
  input  logic                iCoeffUpdate,
  input  logic                iCoeffWr,
  input  logic [ADDR_W-1:0]   iCoeffAddr,
  input  logic [COEFF_W-1:0]  iCoeffData,
  output logic [DELAY_W-1:0]  oDelay,
  output logic                oCsn,
  output logic                oWrn,
  output logic [ADDR_W-1:0]   oAddr,
  output logic [COEFF_W-1:0]  oWrDt,
  output logic                oEnMAC,
  input  logic [COEFF_W-1:0]  iMac,
  output logic [COEFF_W-1:0]  oFirOut,
  output logic                oFirOutVld,
  output logic                oBusy,
  output logic                oSampleOvf
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_tap;
  logic                r_csn;
  logic                r_wrn;
  logic [ADDR_W-1:0]   r_addr;
  logic [COEFF_W-1:0]  r_wrdt;
  logic                r_enmac;
  logic [COEFF_W-1:0]  r_firout;
  logic                r_vld;
  logic                r_busy;
  logic                w_accept;

  // Update mode wins over a coincident sample; samples are only taken in IDLE.
  assign w_accept = (r_state == IDLE) && iEnSample && !iCoeffUpdate;

  fir_delay_chain u_delay_chain (
    .iClk    (iClk12M),
    .iRst    (iRst),
    .iShift  (w_accept),
    .iSample (iFirIn),
    .oDelay  (oDelay)
  );

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_tap    <= '0;
      r_csn    <= 1'b1;
      r_wrn    <= 1'b1;
      r_addr   <= '0;
      r_wrdt   <= '0;
      r_enmac  <= 1'b0;
      r_firout <= '0;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // NOTE: strobes default to idle every cycle so each state only states when it asserts them.
      r_csn   <= 1'b1;
      r_wrn   <= 1'b1;
      r_vld   <= 1'b0;
      // MAC enable trails the read strobe by the one-cycle SRAM read latency.
      r_enmac <= ~r_csn & r_wrn;

      case (r_state)
        IDLE: begin
          if (iCoeffUpdate) begin
            r_state <= UPDATE;
            r_busy  <= 1'b1;
          end else if (iEnSample) begin
            r_state <= READ;
            r_tap   <= '0;
            r_addr  <= '0;
            r_csn   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        UPDATE: begin
          if (iCoeffWr && addr_in_range(iCoeffAddr)) begin
            r_csn  <= 1'b0;
            r_wrn  <= 1'b0;
            r_addr <= iCoeffAddr;
            r_wrdt <= iCoeffData;
          end
          if (!iCoeffUpdate) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        READ: begin
          if (r_tap == LAST_ADDR) begin
            r_tap   <= '0;
            r_state <= DRAIN;
          end else begin
            r_tap  <= r_tap + 1'b1;
            r_addr <= r_tap + 1'b1;
            r_csn  <= 1'b0;
          end
        end

        DRAIN: begin
          r_state <= CAPTURE;
        end

        CAPTURE: begin
          r_firout <= iMac;
          r_vld    <= 1'b1;
          r_state  <= IDLE;
          r_busy   <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oCsn       = r_csn;
  assign oWrn       = r_wrn;
  assign oAddr      = r_addr;
  assign oWrDt      = r_wrdt;
  assign oEnMAC     = r_enmac;
  assign oFirOut    = r_firout;
  assign oFirOutVld = r_vld;
  assign oBusy      = r_busy;

`ifdef FIR_SAMPLE_OVF_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = iEnSample && !w_accept;

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign oSampleOvf = r_ovf;
`else
  assign oSampleOvf = 1'b0;
`endif

endmodule

// File: doc/fir_mac_sched.md
# fir_mac_sched

Sequencing controller for the 10-tap FIR datapath. Owns the input delay chain and the coefficient SpSram port. Drives the MAC enable so each input sample gets exactly ten accumulate cycles, then registers the filter result. Sits between the sample source / host coefficient interface and the SpSram + MAC pair.

## Interface
- NUM_TAP, 10, taps per sample; equals MAC accumulate depth and SRAM depth
- SAMPLE_W, 3, signed sample width; oDelay width = NUM_TAP*SAMPLE_W
- COEFF_W, 16, coefficient and result width
- iClk12M  in  1  sole clock
- iRst  in  1  reset, asynchronous, active-high
- iEnSample  in  1  one-cycle strobe: iFirIn is valid
- iFirIn  in  3  signed input sample
- iCoeffUpdate  in  1  level: host coefficient load mode
- iCoeffWr  in  1  host write strobe (honoured only in UPDATE)
- iCoeffAddr  in  4  host write address
- iCoeffData  in  16  host write data
- oDelay  out  30  delay chain to MAC; [2:0] newest, [29:27] oldest
- oCsn  out  1  SRAM chip select, active-low
- oWrn  out  1  SRAM write enable, active-low
- oAddr  out  4  SRAM address
- oWrDt  out  16  SRAM write data
- oEnMAC  out  1  MAC accumulate enable
- iMac  in  16  MAC result
- oFirOut  out  16  registered filter output
- oFirOutVld  out  1  one-cycle pulse: oFirOut updated
- oBusy  out  1  high outside IDLE
- oSampleOvf  out  1  sticky dropped-sample flag (see Configuration)

## Operation
- All outputs registered. Reset values: oDelay=0, oCsn=1, oWrn=1, oAddr=0, oWrDt=0, oEnMAC=0, oFirOut=0, oFirOutVld=0, oBusy=0, oSampleOvf=0. State=IDLE, tap counter=0.
- States:
  - IDLE: iCoeffUpdate=1 → UPDATE. Otherwise, iEnSample=1 → shift oDelay <= {oDelay[26:0], iFirIn}, clear counter, go to READ.
  - UPDATE: each iCoeffWr with iCoeffAddr<=9 drives oCsn=0, oWrn=0, oAddr, oWrDt on the next cycle. Addresses 10–15 are ignored (oCsn stays 1). iCoeffUpdate=0 → IDLE.
  - READ: 10 cycles; oCsn=0, oWrn=1, oAddr=counter 0..9; counter wraps 9→0, then → DRAIN.
  - DRAIN: waits out the final MAC accumulate → CAPTURE.
  - CAPTURE: oFirOut <= iMac, oFirOutVld pulses → IDLE.
- oEnMAC is the READ-cycle indicator delayed one cycle, matching the 1-cycle SRAM read latency. It is high for exactly 10 consecutive cycles per sample, which keeps the MAC's internal tap index aligned.
- Priority in IDLE: iCoeffUpdate over iEnSample. A sample arriving simultaneously is dropped.
- iEnSample outside IDLE is dropped: no shift, no extra oEnMAC.
- iCoeffUpdate raised during READ/DRAIN/CAPTURE is held off until IDLE; the current run completes.
- Reset mid-run: async clear to reset values. The system top ties the MAC reset to the same event (MAC iRsn = ~iRst) so its tap index restarts at 0.

## Timing
- E0 = the edge sampling iEnSample=1 in IDLE.
- oDelay new after E0. oAddr=k in the cycle after E(k), k=0..9.
- oEnMAC high after E1 through E10 (10 cycles). MAC final accumulate occurs at E11.
- oFirOut/oFirOutVld update at E12. oBusy high after E0 until E12 returns to IDLE.
- Minimum sample spacing: 13 cycles.
- UPDATE write latency: 1 cycle, strobe to SRAM pins.

## Configuration
- FIR_SAMPLE_OVF_EN defined: oSampleOvf sets on any dropped iEnSample (busy, UPDATE, or losing to iCoeffUpdate). It is sticky until iRst.
- Not defined: oSampleOvf tied 0; drop behaviour otherwise identical.

## Structure
- fir_pkg holds NUM_TAP, SAMPLE_W, COEFF_W, ADDR_W=4, the state enum (IDLE, UPDATE, READ, DRAIN, CAPTURE), and LAST_TAP=NUM_TAP-1.
- One sub-module: fir_delay_chain (shift register with enable, async clear, parallel oDelay out).

## Test plan
- Reset: assert iRst mid-clock → all outputs at listed reset values asynchronously; oCsn=1, oEnMAC=0.
- Coefficient load: iCoeffUpdate=1, write data 1..10 to addresses 0..9 → SRAM sees ten writes one cycle after each strobe. A write to address 12 gives no oCsn assertion.
- Run timing: strobe iFirIn=1 at E0 → oAddr 0..9 after E0..E9, oEnMAC high exactly 10 cycles starting after E1, oFirOutVld single pulse after E12.
- Impulse response with SRAM+MAC models: samples 1,0,0,… spaced 13 cycles → oFirOut = 1,2,3,…,10, then 0. A sample of -1 (3'b111) → -1,-2,….
- Overrun (FIR_SAMPLE_OVF_EN): second strobe 5 cycles after E0 → no extra oEnMAC, oDelay unchanged, oSampleOvf=1 and held. Without the macro, oSampleOvf=0.
- Reset at READ tap 5, then resume (MAC reset too) → next sample produces the correct impulse value; no residual enables.
